conv3x3_stream_filter: RTL and testbench

CONV3X3_STREAM_FILTER -- requirements
Module: conv3x3_stream_filter

---
 rtl/conv3x3_pkg.sv | 39 +++
 rtl/conv3x3_line_buffer.sv | 28 ++
 rtl/conv3x3_stream_filter.sv | 116 +++++++++++
 tb/tb_conv3x3_stream_filter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_pkg.sv
// Shared types and constants for the 3x3 streaming convolution filter.
// Kernel tables are indexed row*3+col over the window, row 0 = oldest line.
package conv3x3_pkg;

    typedef enum logic [1:0] {
        MODE_IDENTITY = 2'd0,
        MODE_SHARPEN  = 2'd1,
        MODE_GAUSS    = 2'd2,
        MODE_LAPLACE  = 2'd3
    } mode_e;

    typedef logic signed [4:0] coef_t;
    typedef coef_t [8:0] kern_t;

    localparam kern_t K_IDENTITY = '{ 5'sd0,  5'sd0,  5'sd0,
                                      5'sd0,  5'sd1,  5'sd0,
                                      5'sd0,  5'sd0,  5'sd0};
    localparam kern_t K_SHARPEN  = '{ 5'sd0, -5'sd1,  5'sd0,
                                     -5'sd1,  5'sd5, -5'sd1,
                                      5'sd0, -5'sd1,  5'sd0};
    localparam kern_t K_GAUSS    = '{ 5'sd1,  5'sd2,  5'sd1,
                                      5'sd2,  5'sd4,  5'sd2,
                                      5'sd1,  5'sd2,  5'sd1};
    localparam kern_t K_LAPLACE  = '{-5'sd1, -5'sd1, -5'sd1,
                                     -5'sd1,  5'sd8, -5'sd1,
                                     -5'sd1, -5'sd1, -5'sd1};

    localparam int GAUSS_SHIFT = 4;

    function automatic kern_t kernel(input mode_e m);
        case (m)
            MODE_SHARPEN: return K_SHARPEN;
            MODE_GAUSS:   return K_GAUSS;
            MODE_LAPLACE: return K_LAPLACE;
            default:      return K_IDENTITY;
        endcase
    endfunction

endpackage

// File: rtl/conv3x3_line_buffer.sv
// Two chained line memories: row1 returns line r-1, row2 returns line r-2 at the
// same column; each accepted pixel reads both and pushes the column down a line.
module conv3x3_line_buffer #(
    parameter int IMG_W = 256,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(IMG_W)-1:0] addr,
    input  logic [PIX_W-1:0]         din,
    output logic [PIX_W-1:0]         row1,
    output logic [PIX_W-1:0]         row2
);

    logic [PIX_W-1:0] mem1 [IMG_W];
    logic [PIX_W-1:0] mem2 [IMG_W];

    assign row1 = mem1[addr];
    assign row2 = mem2[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem1[addr] <= din;
            mem2[addr] <= mem1[addr];
        end
    end

endmodule

// File: rtl/conv3x3_stream_filter.sv
// Raster-stream 3x3 convolution: position counters, window, MAC stage, clamp stage.
// Output is centred one row and one column behind the accepted pixel.
module conv3x3_stream_filter
    import conv3x3_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ACC_W  = PIX_W + 6;
    localparam int STAGES = 2;
    localparam logic [COL_W-1:0]        COL_LAST = COL_W'(IMG_W - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'((1 << PIX_W) - 1);

    logic [COL_W-1:0]        col, cur_col;
    logic [1:0]              row, cur_row;   // saturates at 2: only r>=2 matters
    logic                    active, produce;
    mode_e                   mode_q, acc_mode;
    logic [STAGES:0]         vld_pipe;
    logic [8:0][PIX_W-1:0]   win;
    logic [PIX_W-1:0]        lb_row1, lb_row2;
    kern_t                   kern;
    logic signed [ACC_W-1:0] sum, acc, scaled;
    logic [PIX_W-1:0]        clamped;

    always_comb begin
        cur_col = in_sof ? '0 : col;
        cur_row = in_sof ? 2'd0 : row;
        produce = in_valid && active && !in_sof && (row == 2'd2) && (col >= COL_W'(2));
    end

    conv3x3_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb (
        .clk  (clk),
        .en   (in_valid),
        .addr (cur_col),
        .din  (in_pixel),
        .row1 (lb_row1),
        .row2 (lb_row2)
    );

    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r*3]   <= win[r*3+1];
                win[r*3+1] <= win[r*3+2];
            end
            win[2] <= lb_row2;
            win[5] <= lb_row1;
            win[8] <= in_pixel;
        end
    end

    // Stage 1: signed multiply-accumulate over the window.
    always_comb begin
        kern = kernel(mode_q);
        sum  = '0;
        for (int i = 0; i < 9; i++)
            sum = sum + ACC_W'($signed({1'b0, win[i]})) * ACC_W'($signed(kern[i]));
    end

    // The mode travels with the sum so a new frame's in_sof cannot rescale it.
    always_ff @(posedge clk) begin
        acc      <= sum;
        acc_mode <= mode_q;
    end

    // Stage 2: scale and clamp.
    always_comb begin
        scaled = (acc_mode == MODE_GAUSS) ? (acc >>> GAUSS_SHIFT) : acc;
        if (scaled[ACC_W-1])
            clamped = '0;
        else if (scaled > PIX_MAX)
            clamped = '1;
        else
            clamped = scaled[PIX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            active    <= 1'b0;
            mode_q    <= MODE_IDENTITY;
            vld_pipe  <= '0;
            out_pixel <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], produce};
            if (in_valid) begin
                if (in_sof) begin
                    active <= 1'b1;
                    mode_q <= mode_e'(mode);
                end
                col <= (cur_col == COL_LAST) ? '0 : cur_col + COL_W'(1);
                if (cur_col == COL_LAST && cur_row != 2'd2)
                    row <= cur_row + 2'd1;
                else
                    row <= cur_row;
            end
            if (vld_pipe[STAGES-1])
                out_pixel <= clamped;
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_conv3x3_stream_filter.sv
// Directed bench for conv3x3_stream_filter on an 8x6 frame with one odd pixel at (3,3).
// Expected outputs are hand-computed per pixel class around that spot.
module tb_conv3x3_stream_filter;

    localparam int IMG_W = 8;
    localparam int PIX_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [PIX_W-1:0] in_pixel = '0;
    logic             out_valid;
    logic [PIX_W-1:0] out_pixel;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] oq[$];
    int         oc[$];

    conv3x3_stream_filter #(.IMG_W(IMG_W), .PIX_W(PIX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_pixel (out_pixel)
    );

    always #5 clk = ~clk;

    // Edge numbering: an input driven at a negedge is accepted at edge cyc+1.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (out_valid === 1'b1) begin
            oq.push_back(out_pixel);
            oc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output i is centred at (i/6+1, i%6+1); classify it relative to the spot at (3,3).
    function automatic int exp_val(input int i, input int ec, input int ee, input int ek, input int ef);
        int cr, cc, dr, dc;
        cr = i / 6 + 1;
        cc = i % 6 + 1;
        dr = (cr > 3) ? cr - 3 : 3 - cr;
        dc = (cc > 3) ? cc - 3 : 3 - cc;
        if (dr == 0 && dc == 0) return ec;
        if (dr + dc == 1)       return ee;
        if (dr == 1 && dc == 1) return ek;
        return ef;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic drive(input logic [7:0] p, input logic s, input logic [1:0] m);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = s;
        in_pixel = p;
        mode     = m;
    endtask

    task automatic run_frame(input string nm, input int bg, input int sp, input logic [1:0] m0,
                             input logic [1:0] m1, input bit gaps,
                             input int ec, input int ee, input int ek, input int ef);
        int ea[$];
        oq.delete();
        oc.delete();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (gaps)
                    while ($urandom_range(1) == 1) idle(1);
                drive((r == 3 && c == 3) ? 8'(sp) : 8'(bg), (r == 0 && c == 0),
                      (r == 0 && c == 0) ? m0 : m1);
                if (r >= 2 && c >= 2) ea.push_back(cyc + 1);
            end
        end
        idle(5);
        n_cmp++;
        if (oq.size() != 24) begin
            n_bad++;
            $display("FAIL %s count: got %0d want 24", nm, oq.size());
        end
        for (int i = 0; i < oq.size() && i < 24; i++) begin
            int e;
            e = exp_val(i, ec, ee, ek, ef);
            n_cmp++;
            if (oq[i] !== 8'(e)) begin
                n_bad++;
                $display("FAIL %s pix[%0d]: got %0d want %0d", nm, i, oq[i], e);
            end
            n_cmp++;
            if (oc[i] != ea[i] + 2) begin
                n_bad++;
                $display("FAIL %s latency[%0d]: out at edge %0d want %0d", nm, i, oc[i], ea[i] + 2);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_pixel !== 8'd0) begin
            n_bad++;
            $display("FAIL reset out_pixel: got %0d want 0", out_pixel);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_flat();
        run_frame("flat_identity", 100, 100, 2'd0, 2'd0, 1'b0, 100, 100, 100, 100);
        run_frame("flat_sharpen",  100, 100, 2'd1, 2'd1, 1'b0, 100, 100, 100, 100);
        run_frame("flat_gauss",    100, 100, 2'd2, 2'd2, 1'b0, 100, 100, 100, 100);
        run_frame("flat_laplace",  100, 100, 2'd3, 2'd3, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic test_spot();
        run_frame("spot_sharpen",  0, 255, 2'd1, 2'd1, 1'b0, 255, 0, 0, 0);
        run_frame("spot_laplace",  0, 255, 2'd3, 2'd3, 1'b0, 255, 0, 0, 0);
        run_frame("spot_gauss",    0, 255, 2'd2, 2'd2, 1'b0, 63, 31, 15, 0);
        run_frame("spot_identity", 0, 255, 2'd0, 2'd0, 1'b0, 255, 0, 0, 0);
    endtask

    task automatic test_dip();
        run_frame("dip_sharpen", 100, 40, 2'd1, 2'd1, 1'b0, 0, 160, 100, 100);
        run_frame("dip_laplace", 100, 40, 2'd3, 2'd3, 1'b0, 0, 60, 60, 0);
        run_frame("dip_gauss",   100, 40, 2'd2, 2'd2, 1'b0, 85, 92, 96, 100);
    endtask

    task automatic test_gaps();
        run_frame("gaps_dip_gauss",     100, 40, 2'd2, 2'd2, 1'b1, 85, 92, 96, 100);
        run_frame("gaps_spot_sharpen",  0, 255, 2'd1, 2'd1, 1'b1, 255, 0, 0, 0);
    endtask

    task automatic test_mode_latch();
        run_frame("mode_mid_change", 100, 40, 2'd1, 2'd3, 1'b0, 0, 160, 100, 100);
        run_frame("mode_next_frame", 100, 40, 2'd3, 2'd3, 1'b0, 0, 60, 60, 0);
    endtask

    task automatic test_abort();
        oq.delete();
        oc.delete();
        // rows 0..2 plus (3,0)..(3,3); the next pixel is the new frame's in_sof
        for (int k = 0; k < 28; k++) drive(8'd200, (k == 0), 2'd3);
        idle(5);
        n_cmp++;
        if (oq.size() != 8) begin
            n_bad++;
            $display("FAIL abort_partial count: got %0d want 8", oq.size());
        end
        for (int i = 0; i < oq.size(); i++) begin
            n_cmp++;
            if (oq[i] !== 8'd0) begin
                n_bad++;
                $display("FAIL abort_partial pix[%0d]: got %0d want 0", i, oq[i]);
            end
        end
        run_frame("abort_new_frame", 100, 40, 2'd2, 2'd2, 1'b0, 85, 92, 96, 100);
    endtask

    task automatic test_mid_reset();
        oq.delete();
        oc.delete();
        // k=18 is (2,2), which would produce an output
        for (int k = 0; k < 19; k++) drive(8'd100, (k == 0), 2'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        n_cmp++;
        if (oq.size() != 0) begin
            n_bad++;
            $display("FAIL mid_reset outputs: got %0d want 0", oq.size());
        end
        n_cmp++;
        if (out_pixel !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_reset out_pixel: got %0d want 0", out_pixel);
        end
    endtask

    task automatic test_no_sof();
        oq.delete();
        oc.delete();
        for (int k = 0; k < 48; k++) drive(8'd100, 1'b0, 2'd1);
        idle(5);
        n_cmp++;
        if (oq.size() != 0) begin
            n_bad++;
            $display("FAIL no_sof outputs: got %0d want 0", oq.size());
        end
        run_frame("after_no_sof", 100, 100, 2'd1, 2'd1, 1'b0, 100, 100, 100, 100);
    endtask

    initial begin
        test_reset();
        test_flat();
        test_spot();
        test_dip();
        test_gaps();
        test_mode_latch();
        test_abort();
        test_mid_reset();
        test_no_sof();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
